// File: rtl/adc_fifo_writer.sv
// ADC sample FIFO write side: capture control, 12/8-bit sample packing into 48-bit words, error/underflow status and stream segment pulses.
// Optional test-pattern source enabled by defining ADC_FIFO_WRITER_PATTERN_EN (adds pattern_en input).
module adc_fifo_writer #(
    parameter int pNUM_SAMPLES_W = 20,
    parameter int pERR_W         = 9
) (
    input  logic                      adc_sampleclk,
    input  logic                      reset_n,
    input  logic [11:0]               adc_data,
    input  logic                      arm,
    input  logic                      trigger,
    input  logic [pNUM_SAMPLES_W-1:0] num_samples,
    input  logic                      low_res,
    input  logic                      low_res_lsb,
    input  logic [16:0]               stream_segment_threshold,
    input  logic                      clear_fifo_errors,
    input  logic                      no_underflow_errors,
    input  logic                      fifo_full,
    input  logic                      fifo_empty,
    input  logic                      fifo_rd_en,
`ifdef ADC_FIFO_WRITER_PATTERN_EN
    input  logic                      pattern_en,
`endif
    output logic                      fifo_wr_en,
    output logic [47:0]               fifo_din,
    output logic [2:0]                fifo_state,
    output logic [pERR_W-1:0]         fifo_error_stat,
    output logic [pERR_W-1:0]         fifo_first_error_stat,
    output logic [2:0]                fifo_first_error_state,
    output logic [7:0]                underflow_count,
    output logic                      capture_done,
    output logic                      segment_done
);

    // Enum order is the fifo_state encoding reported to the register block.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_FLUSH   = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERROR   = 3'd5
    } state_t;

    state_t                    r_state;
    logic [pNUM_SAMPLES_W-1:0] r_sample_cnt;
    logic [2:0]                r_slot;
    logic [47:0]               r_word;
    logic                      r_low_res;
    logic                      r_low_res_lsb;
    logic [16:0]               r_seg_cnt;
    logic                      r_wr_en;
    logic [47:0]               r_din;
    logic                      r_capture_done;
    logic                      r_segment_done;
    logic [pERR_W-1:0]         r_err;
    logic [pERR_W-1:0]         r_first_err;
    logic [2:0]                r_first_state;
    logic [7:0]                r_uf_cnt;
`ifdef ADC_FIFO_WRITER_PATTERN_EN
    logic [11:0]               r_pat_cnt;
`endif

    logic [pNUM_SAMPLES_W-1:0] w_n_eff;
    logic [pNUM_SAMPLES_W-1:0] w_cnt_next;
    logic                      w_last_sample;
    logic                      w_sample_en;
    logic                      w_slot_last;
    logic [11:0]               w_s12;
    logic [7:0]                w_s8;
    logic [5:0]                w_shamt;
    logic [47:0]               w_place;
    logic [47:0]               w_word_next;
    logic                      w_write_due;
    logic                      w_ovf;
    logic                      w_uf;
    logic                      w_rearm;
    logic [pERR_W-1:0]         w_err_set;
    logic [16:0]               w_seg_next;

    assign w_n_eff       = (num_samples == '0) ? pNUM_SAMPLES_W'(1) : num_samples;
    assign w_cnt_next    = r_sample_cnt + pNUM_SAMPLES_W'(1);
    assign w_last_sample = (w_cnt_next >= w_n_eff);
    assign w_sample_en   = (r_state == ST_CAPTURE) || ((r_state == ST_ARMED) && trigger);
    assign w_slot_last   = r_low_res ? (r_slot == 3'd5) : (r_slot == 3'd3);
    assign w_seg_next    = r_seg_cnt + 17'd1;

    always_comb begin
        w_s12 = adc_data;
        w_s8  = r_low_res_lsb ? adc_data[7:0] : adc_data[11:4];
`ifdef ADC_FIFO_WRITER_PATTERN_EN
        if (pattern_en) begin
            w_s12 = r_pat_cnt;
            w_s8  = r_pat_cnt[7:0];
        end
`endif
    end

    // Slot 0 is the most significant; shift = (slots-1-slot) * sample width.
    always_comb begin
        if (r_low_res) begin
            w_shamt = 6'd40 - {r_slot, 3'b000};
            w_place = {40'd0, w_s8} << w_shamt;
        end else begin
            w_shamt = 6'd36 - ({r_slot, 3'b000} + {1'b0, r_slot, 2'b00});
            w_place = {36'd0, w_s12} << w_shamt;
        end
        w_word_next = ((r_slot == 3'd0) ? 48'd0 : r_word) | w_place;
    end

    assign w_write_due = !arm && ((w_sample_en && w_slot_last) ||
                                  ((r_state == ST_FLUSH) && (r_slot != 3'd0)));
    assign w_ovf       = w_write_due && fifo_full;
    assign w_uf        = fifo_rd_en && fifo_empty && !no_underflow_errors;
    assign w_rearm     = arm && ((r_state == ST_CAPTURE) || (r_state == ST_FLUSH));

    always_comb begin
        w_err_set    = '0;
        w_err_set[0] = w_ovf;
        w_err_set[1] = w_uf;
        w_err_set[2] = w_rearm;
    end

    always_ff @(posedge adc_sampleclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_sample_cnt   <= '0;
            r_slot         <= 3'd0;
            r_word         <= 48'd0;
            r_low_res      <= 1'b0;
            r_low_res_lsb  <= 1'b0;
            r_seg_cnt      <= 17'd0;
            r_wr_en        <= 1'b0;
            r_din          <= 48'd0;
            r_capture_done <= 1'b0;
            r_segment_done <= 1'b0;
`ifdef ADC_FIFO_WRITER_PATTERN_EN
            r_pat_cnt      <= 12'd0;
`endif
        end else begin
            r_wr_en        <= 1'b0;
            r_segment_done <= 1'b0;
            if (arm) begin
                r_state        <= ST_ARMED;
                r_sample_cnt   <= '0;
                r_slot         <= 3'd0;
                r_word         <= 48'd0;
                r_seg_cnt      <= 17'd0;
                r_capture_done <= 1'b0;
                r_low_res      <= low_res;
                r_low_res_lsb  <= low_res_lsb;
`ifdef ADC_FIFO_WRITER_PATTERN_EN
                r_pat_cnt      <= 12'd0;
`endif
            end else begin
                if (r_wr_en && (stream_segment_threshold != 17'd0)) begin
                    if (w_seg_next >= stream_segment_threshold) begin
                        r_seg_cnt      <= 17'd0;
                        r_segment_done <= 1'b1;
                    end else begin
                        r_seg_cnt <= w_seg_next;
                    end
                end
                case (r_state)
                    ST_ARMED, ST_CAPTURE: begin
                        if (w_sample_en) begin
                            r_sample_cnt <= w_cnt_next;
`ifdef ADC_FIFO_WRITER_PATTERN_EN
                            r_pat_cnt    <= r_pat_cnt + 12'd1;
`endif
                            if (w_ovf) begin
                                r_state <= ST_ERROR;
                            end else begin
                                if (w_slot_last) begin
                                    r_slot  <= 3'd0;
                                    r_wr_en <= 1'b1;
                                    r_din   <= w_word_next;
                                end else begin
                                    r_slot <= r_slot + 3'd1;
                                end
                                r_word  <= w_word_next;
                                r_state <= w_last_sample ? ST_FLUSH : ST_CAPTURE;
                            end
                        end
                    end
                    ST_FLUSH: begin
                        if (w_ovf) begin
                            r_state <= ST_ERROR;
                        end else begin
                            if (r_slot != 3'd0) begin
                                r_wr_en <= 1'b1;
                                r_din   <= r_word;
                                r_slot  <= 3'd0;
                            end
                            r_state        <= ST_DONE;
                            r_capture_done <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Clear dominates any error raised in the same cycle.
    always_ff @(posedge adc_sampleclk or negedge reset_n) begin
        if (!reset_n) begin
            r_err         <= '0;
            r_first_err   <= '0;
            r_first_state <= 3'd0;
            r_uf_cnt      <= 8'd0;
        end else if (clear_fifo_errors) begin
            r_err         <= '0;
            r_first_err   <= '0;
            r_first_state <= 3'd0;
            r_uf_cnt      <= 8'd0;
        end else begin
            r_err <= r_err | w_err_set;
            if ((r_err == '0) && (w_err_set != '0)) begin
                r_first_err   <= w_err_set;
                r_first_state <= r_state;
            end
            if (w_uf && (r_uf_cnt != 8'hFF)) begin
                r_uf_cnt <= r_uf_cnt + 8'd1;
            end
        end
    end

    assign fifo_wr_en             = r_wr_en;
    assign fifo_din               = r_din;
    assign fifo_state             = r_state;
    assign fifo_error_stat        = r_err;
    assign fifo_first_error_stat  = r_first_err;
    assign fifo_first_error_state = r_first_state;
    assign underflow_count        = r_uf_cnt;
    assign capture_done           = r_capture_done;
    assign segment_done           = r_segment_done;

endmodule

// File: tb/tb_adc_fifo_writer.sv
// Scoreboard bench for adc_fifo_writer: expected FIFO words are queued with the stimulus, a negedge monitor pops and compares on every write.
module tb_adc_fifo_writer;

    logic        adc_sampleclk = 1'b0;
    logic        reset_n;
    logic [11:0] adc_data;
    logic        arm;
    logic        trigger;
    logic [19:0] num_samples;
    logic        low_res;
    logic        low_res_lsb;
    logic [16:0] stream_segment_threshold;
    logic        clear_fifo_errors;
    logic        no_underflow_errors;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_rd_en;
`ifdef ADC_FIFO_WRITER_PATTERN_EN
    logic        pattern_en = 1'b0;
`endif
    logic        fifo_wr_en;
    logic [47:0] fifo_din;
    logic [2:0]  fifo_state;
    logic [8:0]  fifo_error_stat;
    logic [8:0]  fifo_first_error_stat;
    logic [2:0]  fifo_first_error_state;
    logic [7:0]  underflow_count;
    logic        capture_done;
    logic        segment_done;

    adc_fifo_writer #(.pNUM_SAMPLES_W(20), .pERR_W(9)) dut (
        .adc_sampleclk          (adc_sampleclk),
        .reset_n                (reset_n),
        .adc_data               (adc_data),
        .arm                    (arm),
        .trigger                (trigger),
        .num_samples            (num_samples),
        .low_res                (low_res),
        .low_res_lsb            (low_res_lsb),
        .stream_segment_threshold(stream_segment_threshold),
        .clear_fifo_errors      (clear_fifo_errors),
        .no_underflow_errors    (no_underflow_errors),
        .fifo_full              (fifo_full),
        .fifo_empty             (fifo_empty),
        .fifo_rd_en             (fifo_rd_en),
`ifdef ADC_FIFO_WRITER_PATTERN_EN
        .pattern_en             (pattern_en),
`endif
        .fifo_wr_en             (fifo_wr_en),
        .fifo_din               (fifo_din),
        .fifo_state             (fifo_state),
        .fifo_error_stat        (fifo_error_stat),
        .fifo_first_error_stat  (fifo_first_error_stat),
        .fifo_first_error_state (fifo_first_error_state),
        .underflow_count        (underflow_count),
        .capture_done           (capture_done),
        .segment_done           (segment_done)
    );

    always #5 adc_sampleclk = ~adc_sampleclk;

    int          checks   = 0;
    int          errors   = 0;
    int          wr_count = 0;
    int          base;
    logic [47:0] exp_q[$];
    int          seg_q[$];
    logic [47:0] mon_exp;
    logic [11:0] t1_data[8] = '{12'h123, 12'h456, 12'h789, 12'hABC,
                                12'h001, 12'h002, 12'h003, 12'h004};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge adc_sampleclk);
            #1;
        end
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_fifo_errors = 1'b1;
        tick(1);
        clear_fifo_errors = 1'b0;
    endtask

    // Monitor: every observed write must match the oldest queued word.
    always @(negedge adc_sampleclk) begin
        if (reset_n) begin
            if (fifo_wr_en) begin
                wr_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual=%h required=no_write", fifo_din);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("fifo_din", 64'(fifo_din), 64'(mon_exp));
                end
            end
            if (segment_done) seg_q.push_back(wr_count);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        adc_data = 12'd0;
        arm = 1'b0;
        trigger = 1'b0;
        num_samples = 20'd0;
        low_res = 1'b0;
        low_res_lsb = 1'b0;
        stream_segment_threshold = 17'd0;
        clear_fifo_errors = 1'b0;
        no_underflow_errors = 1'b0;
        fifo_full = 1'b0;
        fifo_empty = 1'b0;
        fifo_rd_en = 1'b0;
        tick(3);

        check("rst_state",  64'(fifo_state), 64'd0);
        check("rst_wr_en",  64'(fifo_wr_en), 64'd0);
        check("rst_din",    64'(fifo_din), 64'd0);
        check("rst_err",    64'(fifo_error_stat), 64'd0);
        check("rst_ucount", 64'(underflow_count), 64'd0);
        check("rst_done",   64'(capture_done), 64'd0);
        reset_n = 1'b1;
        tick(2);

        // Full-res capture of 8 samples.
        num_samples = 20'd8;
        pulse_arm();
        check("t1_armed", 64'(fifo_state), 64'd1);
        exp_q.push_back(48'h123456789ABC);
        exp_q.push_back(48'h001002003004);
        base = wr_count;
        trigger = 1'b1;
        for (int i = 0; i < 8; i++) begin
            adc_data = t1_data[i];
            tick(1);
        end
        trigger = 1'b0;
        tick(3);
        check("t1_writes", 64'(wr_count - base), 64'd2);
        check("t1_state",  64'(fifo_state), 64'd4);
        check("t1_done",   64'(capture_done), 64'd1);

        // Low-res capture with a partial final word.
        low_res = 1'b1;
        num_samples = 20'd7;
        pulse_arm();
        check("t2_done_cleared", 64'(capture_done), 64'd0);
        exp_q.push_back(48'hABABABABABAB);
        exp_q.push_back(48'hAB0000000000);
        base = wr_count;
        trigger = 1'b1;
        adc_data = 12'hAB0;
        tick(7);
        trigger = 1'b0;
        tick(3);
        check("t2_writes", 64'(wr_count - base), 64'd2);
        check("t2_state",  64'(fifo_state), 64'd4);

        // Overflow on the second write of a 16-sample capture.
        low_res = 1'b0;
        num_samples = 20'd16;
        pulse_arm();
        exp_q.push_back(48'h100101102103);
        base = wr_count;
        trigger = 1'b1;
        for (int i = 0; i < 16; i++) begin
            adc_data = 12'h100 + 12'(i);
            if (i == 4) fifo_full = 1'b1;
            tick(1);
        end
        trigger = 1'b0;
        tick(2);
        fifo_full = 1'b0;
        check("t3_writes",      64'(wr_count - base), 64'd1);
        check("t3_err",         64'(fifo_error_stat), 64'h001);
        check("t3_first_err",   64'(fifo_first_error_stat), 64'h001);
        check("t3_first_state", 64'(fifo_first_error_state), 64'd2);
        check("t3_state",       64'(fifo_state), 64'd5);
        check("t3_done",        64'(capture_done), 64'd0);
        pulse_clear();
        check("t3_cleared", 64'(fifo_error_stat), 64'd0);

        // Underflow saturation, then suppression.
        fifo_rd_en = 1'b1;
        fifo_empty = 1'b1;
        tick(300);
        check("t4_ucount",      64'(underflow_count), 64'd255);
        check("t4_err",         64'(fifo_error_stat), 64'h002);
        check("t4_first_state", 64'(fifo_first_error_state), 64'd5);
        no_underflow_errors = 1'b1;
        tick(50);
        check("t4_ucount_held", 64'(underflow_count), 64'd255);
        check("t4_err_held",    64'(fifo_error_stat), 64'h002);
        fifo_rd_en = 1'b0;
        fifo_empty = 1'b0;
        no_underflow_errors = 1'b0;
        pulse_clear();
        check("t4_ucount_clr", 64'(underflow_count), 64'd0);

        // First error latched by an underflow; re-arm during capture adds bit 2 only.
        fifo_rd_en = 1'b1;
        fifo_empty = 1'b1;
        tick(1);
        fifo_rd_en = 1'b0;
        fifo_empty = 1'b0;
        check("t5_ucount", 64'(underflow_count), 64'd1);
        pulse_arm();
        trigger = 1'b1;
        tick(2);
        check("t5_capture", 64'(fifo_state), 64'd2);
        trigger = 1'b0;
        pulse_arm();
        check("t5_err",         64'(fifo_error_stat), 64'h006);
        check("t5_first_err",   64'(fifo_first_error_stat), 64'h002);
        check("t5_first_state", 64'(fifo_first_error_state), 64'd5);
        check("t5_state",       64'(fifo_state), 64'd1);
        pulse_clear();
        check("t5_clr_err",   64'(fifo_error_stat), 64'd0);
        check("t5_clr_first", 64'(fifo_first_error_stat), 64'd0);
        check("t5_clr_fstate", 64'(fifo_first_error_state), 64'd0);
        check("t5_clr_ucount", 64'(underflow_count), 64'd0);
        check("no_seg_thr0", 64'(seg_q.size()), 64'd0);

        // Segments every 3 words over a 32-sample capture.
        stream_segment_threshold = 17'd3;
        num_samples = 20'd32;
        pulse_arm();
        for (int k = 0; k < 8; k++)
            exp_q.push_back({12'(4*k), 12'(4*k+1), 12'(4*k+2), 12'(4*k+3)});
        base = wr_count;
        seg_q.delete();
        trigger = 1'b1;
        for (int i = 0; i < 32; i++) begin
            adc_data = 12'(i);
            tick(1);
        end
        trigger = 1'b0;
        tick(3);
        check("t6_writes", 64'(wr_count - base), 64'd8);
        check("t6_segs",   64'(seg_q.size()), 64'd2);
        if (seg_q.size() >= 2) begin
            check("t6_seg0", 64'(seg_q[0] - base), 64'd3);
            check("t6_seg1", 64'(seg_q[1] - base), 64'd6);
        end
        check("t6_state", 64'(fifo_state), 64'd4);

        // Asynchronous reset in the middle of a capture while a write is presented.
        pulse_arm();
        exp_q.push_back(48'h000001002003);
        exp_q.push_back(48'h004005006007);
        trigger = 1'b1;
        for (int i = 0; i < 8; i++) begin
            adc_data = 12'(i);
            fifo_rd_en = (i == 2);
            fifo_empty = (i == 2);
            tick(1);
        end
        fifo_rd_en = 1'b0;
        fifo_empty = 1'b0;
        #5;
        check("t7_wr_before", 64'(fifo_wr_en), 64'd1);
        check("t7_uf_before", 64'(underflow_count), 64'd1);
        reset_n = 1'b0;
        #1;
        check("t7_rst_state",  64'(fifo_state), 64'd0);
        check("t7_rst_wr_en",  64'(fifo_wr_en), 64'd0);
        check("t7_rst_din",    64'(fifo_din), 64'd0);
        check("t7_rst_err",    64'(fifo_error_stat), 64'd0);
        check("t7_rst_first",  64'(fifo_first_error_stat), 64'd0);
        check("t7_rst_ucount", 64'(underflow_count), 64'd0);
        check("t7_rst_seg",    64'(segment_done), 64'd0);
        trigger = 1'b0;
        #1;
        reset_n = 1'b1;
        tick(3);
        check("t7_state_after", 64'(fifo_state), 64'd0);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_fifo_writer.md
Name: adc_fifo_writer

Overview:
- Write side of the ADC sample FIFO; counterpart of the register-side FIFO reader.
- Takes ADC samples and packs them into 48-bit FIFO words. Applies arm/trigger/sample-count capture control.
- Produces the FIFO state, error, first-error, underflow-count and capture-done status that the register block reports to USB.
- Also produces the streaming segment pulse.

Parameters:
- pNUM_SAMPLES_W, 20, width of the capture sample-count input.
- pERR_W, 9, width of the error status vectors.

Ports:
- adc_sampleclk  in  1  single clock; all logic on the rising edge.
- reset_n  in  1  reset; asynchronous assert, active-low.
- adc_data  in  12  ADC sample, valid every cycle.
- arm  in  1  single-cycle pulse; starts a new capture.
- trigger  in  1  level; starts sampling while armed.
- num_samples  in  pNUM_SAMPLES_W  samples per capture; 0 is treated as 1.
- low_res  in  1  8-bit sample mode.
- low_res_lsb  in  1  in 8-bit mode, select adc_data[7:0] instead of [11:4].
- stream_segment_threshold  in  17  FIFO words per stream segment.
- clear_fifo_errors  in  1  level; clears all error and underflow status.
- no_underflow_errors  in  1  suppresses flagging of underflow errors.
- fifo_full  in  1  FIFO full flag.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  in  1  read strobe, observed for underflow detection.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_din  out  48  packed FIFO word.
- fifo_state  out  3  current FSM state.
- fifo_error_stat  out  pERR_W  sticky error bits.
- fifo_first_error_stat  out  pERR_W  error bits captured at the first error.
- fifo_first_error_state  out  3  fifo_state captured at the first error.
- underflow_count  out  8  saturating count of underflow events.
- capture_done  out  1  capture completed cleanly.
- segment_done  out  1  one-cycle pulse per completed segment.

Behaviour:
- Reset (reset_n low, asynchronous): all outputs 0, counters 0, FSM in IDLE.
- FSM states and fifo_state encoding:
  - IDLE (0) -arm-> ARMED.
  - ARMED (1) -trigger high-> CAPTURE. The first sample is taken on the cycle trigger is seen high.
  - CAPTURE (2): one sample per cycle. After num_samples samples -> FLUSH.
  - FLUSH (3): if a partial word is pending, write it once with unused slots zero; then -> DONE.
  - DONE (4): capture_done=1. Goes to ARMED on arm.
  - ERROR (5): entered on overflow. Goes to ARMED on arm.
- arm from any state:
  - Clears the sample, word and segment counters, the packing slot and capture_done.
  - Moves the FSM to ARMED.
  - If arm arrives in CAPTURE or FLUSH, error bit 2 (re-arm during capture) is set.
- Sample selection:
  - Full-res (low_res=0): the 12-bit adc_data.
  - low_res=1: adc_data[11:4], or adc_data[7:0] when low_res_lsb=1.
- Packing:
  - The first sample goes in the most significant slot.
  - Full-res: 4 samples per word, sample k in bits [47-12k -: 12].
  - Low-res: 6 samples per word, sample k in bits [47-8k -: 8].
  - low_res and low_res_lsb are sampled at arm and held for the whole capture.
- Write timing: fifo_wr_en pulses for 1 cycle, the cycle after the last slot of a word is filled. fifo_din is valid in the same cycle.
- Overflow: if fifo_full is high in the cycle a write is due:
  - The write is suppressed.
  - Error bit 0 is set.
  - The FSM goes to ERROR and sampling stops.
- Underflow: fifo_rd_en && fifo_empty && !no_underflow_errors:
  - Sets error bit 1.
  - Increments underflow_count, saturating at 255.
  - Applies in any state.
- Error bits [8:3] are reserved and always 0.
- Error clearing: clear_fifo_errors=1 holds fifo_error_stat, the first-error registers and underflow_count at 0.
- If clear_fifo_errors and a new error occur in the same cycle, clear wins.
- First error: when fifo_error_stat transitions from all-zero to nonzero, the same edge latches:
  - fifo_first_error_stat = the new error vector.
  - fifo_first_error_state = the current fifo_state.
  - Both hold until cleared.
- Segments: a word counter increments on every fifo_wr_en.
  - When it reaches stream_segment_threshold: segment_done pulses and the counter returns to 0.
  - A threshold of 0 disables segment_done.
- Counter widths:
  - Sample counter is pNUM_SAMPLES_W bits.
  - Segment counter is 17 bits.
  - Neither wraps during a capture.

Optional Feature:
- Macro ADC_FIFO_WRITER_PATTERN_EN. When defined, a pattern_en input port is added.
- When pattern_en=1, the selected sample is replaced by an incrementing counter. The counter resets to 0 on arm and is truncated to the sample width.
- When the macro is undefined, the port and the counter are absent and ADC data is always used.

Test Plan:
- Full-res capture: num_samples=8, adc_data=0x123,0x456,0x789,0xABC,0x001…0x004 → 2 writes: 0x123456789ABC, then 0x001002003004. fifo_state ends at 4; capture_done=1.
- Low-res partial word: low_res=1, low_res_lsb=0, num_samples=7, adc_data=0xAB0 every cycle → 2 writes: 0xABABABABABAB, then 0xAB0000000000.
- Overflow: fifo_full=1 on the second write of a 16-sample capture → fifo_error_stat=0x001, fifo_first_error_state=2, fifo_state=5, only 1 write seen.
- Underflow: 300 cycles of fifo_rd_en=1, fifo_empty=1 → underflow_count=255, error bit 1 set. Repeating with no_underflow_errors=1 → no change.
- Error clearing and first error: raise an underflow, then arm during CAPTURE → first_error_stat=0x002, error_stat=0x006. Then pulse clear_fifo_errors → all 0.
- Segments and reset: threshold=3, capture of 32 full-res samples → segment_done pulses after writes 3 and 6. reset_n asserted mid-capture → all outputs 0 immediately.
